fifo_rd_stream: RTL

Read-side drain engine for the team's async FIFO (`top`), sitting entirely in the read clock domain. It issues `rinc` to pull words from the FIFO's first-word-fall-through read port into a 2-entry output buffer. It presents those words on a valid/ready stream, with a `last` marker every FRAME_LEN words. It is the consumer counterpart to the write-side traffic generator that feeds the FIFO.

---
 rtl/fifo_rd_pkg.sv | 29 ++
 rtl/fifo_rd_skid2.sv | 67 ++++++
 rtl/fifo_rd_stream.sv | 67 ++++++
 3 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared types for the async-FIFO read-side drain engine (fifo_rd_stream).
// Holds the output-buffer occupancy encoding and the buffered-entry layout.
package fifo_rd_pkg;

    localparam int BUF_DEPTH    = 2;
    localparam int MAX_DATASIZE = 64;
    localparam int FRAME_IDX_W  = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_t;

    // Data is sized for the widest supported word; narrower builds zero-extend.
    typedef struct packed {
        logic                    last;
        logic [MAX_DATASIZE-1:0] data;
    } buf_entry_t;

    function automatic buf_entry_t make_entry(input logic last,
                                              input logic [MAX_DATASIZE-1:0] data);
        buf_entry_t e;
        e.last = last;
        e.data = data;
        return e;
    endfunction

endpackage

// File: rtl/fifo_rd_skid2.sv
// Two-entry circular output buffer for fifo_rd_stream: push from the FIFO side,
// pop on a valid/ready handshake, one word per cycle at full throughput.
module fifo_rd_skid2
    import fifo_rd_pkg::*;
#(
    parameter int DATASIZE = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                push,
    input  logic                push_last,
    input  logic [DATASIZE-1:0] push_data,
    input  logic                ready,
    output logic [DATASIZE-1:0] data,
    output logic                last,
    output logic                valid,
    output logic                full
);

    buf_state_t state;
    buf_entry_t mem [BUF_DEPTH];
    buf_entry_t head;
    logic       wptr;
    logic       rptr;
    logic       pop;
    logic       unused_head_bits;

    assign pop = valid & ready;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= EMPTY;
            wptr  <= 1'b0;
            rptr  <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wptr] <= make_entry(push_last, MAX_DATASIZE'(push_data));
                wptr      <= ~wptr;
            end
            if (pop) begin
                rptr <= ~rptr;
            end
            // Push never arrives in TWO because the read request is gated by full.
            case (state)
                EMPTY: if (push) state <= ONE;
                ONE: begin
                    if (push && !pop)      state <= TWO;
                    else if (!push && pop) state <= EMPTY;
                end
                TWO:   if (pop) state <= ONE;
                default: state <= EMPTY;
            endcase
        end
    end

    assign head  = mem[rptr];
    assign valid = (state != EMPTY);
    assign full  = (state == TWO);
    assign data  = valid ? head.data[DATASIZE-1:0] : '0;
    assign last  = valid & head.last;

    assign unused_head_bits = ^head.data;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-domain drain engine: pops the FWFT async FIFO into a 2-entry buffer and
// streams it out with a frame-end marker. Optional macro FIFO_RD_AREMPTY_BURST_EN.
module fifo_rd_stream
    import fifo_rd_pkg::*;
#(
    parameter int DATASIZE  = 8,
    parameter int FRAME_LEN = 4,
    parameter int CNTSIZE   = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic [DATASIZE-1:0] rdata_i,
    input  logic                rempty_i,
    input  logic                arempty_i,
    output logic                rinc_o,
    output logic [DATASIZE-1:0] m_data_o,
    output logic                m_valid_o,
    input  logic                m_ready_i,
    output logic                m_last_o,
    output logic [CNTSIZE-1:0]  rd_cnt_o
);

    logic                   full;
    logic                   start_ok;
    logic                   frame_end;
    logic [FRAME_IDX_W-1:0] frame_idx;

    assign frame_end = (frame_idx == FRAME_IDX_W'(FRAME_LEN - 1));

`ifdef FIFO_RD_AREMPTY_BURST_EN
    // A frame only begins once the FIFO holds enough to avoid a long mid-frame stall.
    assign start_ok = (frame_idx != '0) | ~arempty_i;
`else
    logic unused_arempty;
    assign unused_arempty = arempty_i;
    assign start_ok       = 1'b1;
`endif

    assign rinc_o = ~rst_i & en_i & ~rempty_i & ~full & start_ok;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            frame_idx <= '0;
            rd_cnt_o  <= '0;
        end else if (rinc_o) begin
            frame_idx <= frame_end ? '0 : frame_idx + 1'b1;
            rd_cnt_o  <= rd_cnt_o + CNTSIZE'(1);
        end
    end

    fifo_rd_skid2 #(
        .DATASIZE (DATASIZE)
    ) u_skid (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (rinc_o),
        .push_last (frame_end),
        .push_data (rdata_i),
        .ready     (m_ready_i),
        .data      (m_data_o),
        .last      (m_last_o),
        .valid     (m_valid_o),
        .full      (full)
    );

endmodule
